// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// lsu_ctrl : load/store sequencer in front of the data memory; splits
//            misaligned half/word accesses into byte accesses.
// Revision  : 1.0
// ============================================================================
module lsu_ctrl #(
    parameter int RD_LATENCY     = 1,
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_memop,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_memop,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    input  logic [31:0] mem_dataout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [1:0] c_WAIT_INIT = 2'(RD_LATENCY - 1);

    state_t      r_state;
    logic        r_we;
    logic        r_split;
    logic [2:0]  r_memop;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_idx;
    logic [1:0]  r_last;
    logic [1:0]  r_wcnt;
    logic [31:0] r_asm;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_reject;
    logic [1:0]  w_next_idx;
    logic [31:0] w_load_data;

    assign w_accept   = req_valid && req_ready;
    assign w_illegal  = (req_memop == 3'b011) || (req_memop[2:1] == 2'b11) ||
                        (req_we && req_memop[2]);
    assign w_misalign = ((req_memop[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_memop[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_reject   = w_illegal || (w_misalign && (ALLOW_MISALIGN == 0));
    assign w_next_idx = r_idx + 2'd1;

    // Aligned loads come back already extended by the memory; only split
    // halfwords need extension here (split words use all 32 assembled bits).
    always_comb begin
        w_load_data = r_asm;
        if (r_split && (r_memop[1:0] == 2'b01)) begin
            w_load_data = r_memop[2] ? {16'h0000, r_asm[15:0]}
                                     : {{16{r_asm[15]}}, r_asm[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_split    <= 1'b0;
            r_memop    <= 3'b000;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_idx      <= 2'd0;
            r_last     <= 2'd0;
            r_wcnt     <= 2'd0;
            r_asm      <= 32'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_addr   <= 32'h0;
            mem_memop  <= 3'b010;
            mem_datain <= 32'h0;
            mem_we     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_we     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we      <= req_we;
                        r_memop   <= req_memop;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_split   <= w_misalign;
                        r_last    <= (req_memop[1:0] == 2'b10) ? 2'd3 : 2'd1;
                        r_idx     <= 2'd0;
                        r_asm     <= 32'h0;
                        req_ready <= 1'b0;
                        if (w_reject) begin
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            r_state    <= S_ACCESS;
                            mem_addr   <= req_addr;
                            mem_we     <= req_we;
                            mem_memop  <= w_misalign ? 3'b100 : req_memop;
                            mem_datain <= w_misalign ? {24'h0, req_wdata[7:0]} : req_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    r_wcnt  <= c_WAIT_INIT;
                    r_state <= r_we ? S_NEXT : S_WAIT;
                end
                S_WAIT: begin
                    if (r_wcnt == 2'd0) begin
                        if (r_split) begin
                            r_asm[{r_idx, 3'b000} +: 8] <= mem_dataout[7:0];
                        end else begin
                            r_asm <= mem_dataout;
                        end
                        r_state <= S_NEXT;
                    end else begin
                        r_wcnt <= r_wcnt - 2'd1;
                    end
                end
                S_NEXT: begin
                    if (r_split && (r_idx != r_last)) begin
                        r_idx      <= w_next_idx;
                        mem_addr   <= r_addr + {30'h0, w_next_idx};
                        mem_memop  <= 3'b100;
                        mem_datain <= {24'h0, r_wdata[{w_next_idx, 3'b000} +: 8]};
                        mem_we     <= r_we;
                        r_state    <= S_ACCESS;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= r_we ? 32'h0 : w_load_data;
                        r_state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer directly upstream of the data memory block. The CPU issues one request at a time to this block.
- The data memory natively handles three aligned cases: byte at any offset, halfword at offset 0 or 2, and word at offset 0.
- This block passes aligned accesses straight through as one access.
- It splits misaligned halfword/word accesses into sequential unsigned-byte accesses, assembles load data little-endian, and applies the final sign/zero extension.
- It returns results over a valid/ready handshake.

Parameters:
- RD_LATENCY, 1: cycles from mem_addr driven until mem_dataout is valid (1..3).
- ALLOW_MISALIGN, 1: 1 = split misaligned accesses; 0 = reject misaligned accesses with resp_err.

Ports:
- clk  input  1  single clock; drives both memory read and write clocks.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_memop  input  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  illegal memop, or misaligned access with ALLOW_MISALIGN=0.
- mem_addr  output  32  address to the data memory.
- mem_memop  output  3  memop to the data memory.
- mem_datain  output  32  write data to the data memory.
- mem_we  output  1  write enable to the data memory.
- mem_dataout  input  32  read data from the data memory.

Behaviour:
- Reset (asynchronous, rstn=0):
  - State = IDLE.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_we=0, mem_addr=0, mem_memop=3'b010, mem_datain=0.
  - Byte counter = 0; assembly register = 0.
- Reset mid-operation aborts the access with no response. mem_we drops to 0 immediately. Bytes already written stay written.
- Accept rule: request is accepted on a rising edge with req_valid && req_ready. All request fields are latched at that edge.
- Classification at accept:
  - Illegal: memop 011, 110 or 111; or a store with memop 100/101.
  - Aligned: byte; half with addr[1:0] in {0,2}; word with addr[1:0]==0.
  - Otherwise misaligned.
- FSM states: IDLE, ACCESS, WAIT, NEXT, RESP.
- IDLE:
  - On accept of an illegal request, or a misaligned request with ALLOW_MISALIGN=0 → RESP with resp_err=1. No memory access is made.
  - On accept of any other request → ACCESS.
- ACCESS (exactly 1 cycle):
  - Aligned: mem_addr=addr, mem_memop=memop, mem_datain=wdata.
  - Split, byte i: mem_addr=addr+i, mem_memop=3'b100, mem_datain={24'b0, wdata[8i+7:8i]}.
  - mem_we=req_we during this cycle only.
  - Next state: store → NEXT; load → WAIT.
- WAIT (RD_LATENCY cycles): mem_addr/mem_memop held. On the last WAIT cycle, capture mem_dataout:
  - Aligned: capture the full word.
  - Split: capture mem_dataout[7:0] into assembly byte i.
  - Then → NEXT.
- NEXT:
  - If split and i < N-1: i+1 → ACCESS, where N=2 for half and 4 for word.
  - Otherwise → RESP.
  - Address arithmetic is 32-bit and wraps modulo 2^32; addr 0xFFFFFFFF split word touches 0xFFFFFFFF, 0x0, 0x1, 0x2.
- RESP (1 cycle):
  - resp_valid=1.
  - Aligned load: resp_rdata = captured value, passed through unchanged.
  - Split load: resp_rdata = assembled value, sign-extended for lh, zero-extended for lhu, full 32 bits for lw.
  - Then → IDLE. req_ready=1 again the following cycle, so back-to-back throughput is 1 request per (latency+1) cycles.
- Latency from accept edge to resp_valid:
  - Aligned store: 3 cycles.
  - Aligned load: 3+RD_LATENCY cycles.
  - Split access: 1 + N×(2+RD_LATENCY·load) cycles.
  - Error: 1 cycle.
- Outputs are registered. mem_we is never high outside ACCESS.

Test Plan:
- Aligned sw: addr 0x100, data 0xDEADBEEF. Follow with lw 0x100 → exactly one mem_we pulse; resp_rdata 0xDEADBEEF; resp_valid 3+RD_LATENCY cycles after accept.
- Misaligned lw at 0x101 after storing words 0x44332211 @0x100 and 0x88776655 @0x104 → four byte reads at 0x101..0x104; resp_rdata 0x55443322.
- Misaligned sh 0xA1B2 at 0x103, then lw 0x100 and lw 0x104 → byte 0x103=0xB2, byte 0x104=0xA1; all other bytes unchanged.
- Misaligned lh at 0x101 covering bytes 0x80,0xFF → resp_rdata 0xFFFFFF80 (sign-extended). Same access as lhu → 0x0000FF80.
- Illegal memop 3'b111, and (with ALLOW_MISALIGN=0) lw at 0x102 → resp_err=1 after 1 cycle; resp_rdata=0; no mem_we; no address change.
- Assert rstn=0 during the second byte write of a split sw → mem_we low asynchronously; req_ready=1; resp_valid never pulses; next request is processed normally.
